// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver. It synchronizes the line, samples each bit at mid-bit and hands off one byte at a time on a valid/ready handshake.
// It reports framing errors and overrun errors with sticky flags.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       serial_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;
  state_t                 state_reg;
  logic [CW-1:0]          cnt_reg;
  logic [2:0]             bit_idx_reg;
  logic [7:0]             shift_reg;

  // Synchronizer flops reset to idle-high, so a reset never looks like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '1;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], serial_in};
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];
  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // Clears come first, so an error set later in this block takes priority
      if (err_clr) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (!ena) begin
        state_reg   <= IDLE;
        cnt_reg     <= '0;
        bit_idx_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (!rx_s) begin
              state_reg <= START;
              cnt_reg   <= '0;
            end
          end
          START: begin
            if (cnt_reg == HALF_LAST) begin
              cnt_reg <= '0;
              if (!rx_s) begin
                state_reg   <= DATA;
                bit_idx_reg <= '0;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          DATA: begin
            if (cnt_reg == BIT_LAST) begin
              cnt_reg                <= '0;
              shift_reg[bit_idx_reg] <= rx_s;
              if (bit_idx_reg == 3'd7) state_reg <= STOP;
              else                     bit_idx_reg <= bit_idx_reg + 3'd1;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          STOP: begin
            if (cnt_reg == BIT_LAST) begin
              cnt_reg <= '0;
              if (rx_s) begin
                state_reg <= IDLE;
                // Load only when the holding register is free or being drained this cycle
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shift_reg;
                  rx_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                state_reg <= BREAK;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          BREAK: begin
            if (rx_s) state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx with 16 clocks per bit.
// The stimulus pushes the bytes it expects, and a monitor checks every accepted handshake against them.
module tb_uart_byte_rx;
  localparam int CPB = 16;

  logic       clk = 0;
  logic       rst = 1;
  logic       ena = 1;
  logic       serial_in = 1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       err_clr = 0;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  uart_byte_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .serial_in(serial_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  // Monitor: every accepted byte must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_byte: got %02h expected none", rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          fails++;
          $display("FAIL rx_byte: got %02h expected %02h", rx_data, e);
        end else begin
          $display("[TB] rx byte %02h ok", rx_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    serial_in = 1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] p;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_flags", {frame_err, overrun}, 2'b00);
    @(posedge clk); #1;
    rst = 0;
    idle(5);

    // 1: single byte
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    idle(20);
    @(negedge clk);
    check("t1_busy", busy, 0);
    check("t1_rx_valid", rx_valid, 0);
    check("t1_flags", {frame_err, overrun}, 2'b00);

    // 2: back-to-back frames
    exp_q.push_back(8'h3C); exp_q.push_back(8'h7F); exp_q.push_back(8'hC1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h7F, 1'b1);
    send_byte(8'hC1, 1'b1);
    idle(20);
    @(negedge clk);
    check("t2_drained", exp_q.size(), 0);

    // 3: overrun while the holding register is full
    rx_ready = 0;
    exp_q.push_back(8'h99);
    send_byte(8'h99, 1'b1);
    idle(10);
    send_byte(8'h42, 1'b1);
    idle(20);
    @(negedge clk);
    check("t3_hold_data", rx_data, 8'h99);
    check("t3_hold_valid", rx_valid, 1);
    check("t3_overrun", overrun, 1);
    @(posedge clk); #1;
    rx_ready = 1;
    idle(5);
    @(negedge clk);
    check("t3_valid_cleared", rx_valid, 0);
    @(posedge clk); #1;
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    @(negedge clk);
    check("t3_overrun_clr", overrun, 0);

    // 4: framing error followed by a long break
    drive_bit(1'b0);
    p = 8'hE7;
    for (int i = 0; i < 8; i++) drive_bit(p[i]);
    serial_in = 0;
    repeat (40) @(posedge clk);
    #1;
    @(negedge clk);
    check("t4_frame_err", frame_err, 1);
    check("t4_in_break", busy, 1);
    check("t4_no_valid", rx_valid, 0);
    idle(20);
    @(negedge clk);
    check("t4_busy_after", busy, 0);
    exp_q.push_back(8'hB8);
    send_byte(8'hB8, 1'b1);
    idle(20);
    @(posedge clk); #1;
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    @(negedge clk);
    check("t4_frame_err_clr", frame_err, 0);

    // 5: short glitch on the idle line
    serial_in = 0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_flags", {frame_err, overrun}, 2'b00);
    check("t5_rx_valid", rx_valid, 0);

    // 6: reset in the middle of bit 3
    p = 8'h5D;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(p[i]);
    serial_in = p[3];
    repeat (8) @(posedge clk);
    #1;
    rst = 1;
    serial_in = 1;
    @(negedge clk);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_data", rx_data, 8'h00);
    check("t6_rst_valid", rx_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    idle(CPB * 8);
    @(negedge clk);
    check("t6_no_partial", rx_valid, 0);
    exp_q.push_back(8'hF0);
    send_byte(8'hF0, 1'b1);
    idle(5);
    @(negedge clk);
    check("t6_rx_data", rx_data, 8'hF0);
    idle(20);
    @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
UART receiver stage directly upstream of the Trivium cipher core. It recovers 8N1 bytes from the asynchronous serial_in line (idle high, LSB first) and presents each byte on a valid/ready handshake for the keystream XOR stage. It provides one byte of holding buffer, glitch rejection on the start bit, and framing and overrun error reporting.

Parameters:
CLKS_PER_BIT, 10417, clk cycles per bit (100 MHz / 9600 baud); legal range 8 or more.
SYNC_STAGES, 2, flops in the serial_in metastability synchronizer; legal range 2 or more.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
ena  input  1  block enable; when low, the FSM holds in IDLE and ignores the line.
serial_in  input  1  raw UART line, idle high.
rx_data  output  8  received byte; stable while rx_valid=1.
rx_valid  output  1  rx_data holds an unconsumed byte.
rx_ready  input  1  downstream accepts the byte when rx_valid & rx_ready.
busy  output  1  high whenever the FSM is not in IDLE.
frame_err  output  1  sticky; set when a stop bit is sampled low.
overrun  output  1  sticky; set when a byte completes while the holding register is still full.
err_clr  input  1  single-cycle pulse that clears frame_err and overrun.

Behaviour:
- Reset values: rx_data=8'h00, rx_valid=0, busy=0, frame_err=0, overrun=0. Synchronizer flops reset to 1 (idle). FSM resets to IDLE; bit counter and cycle counter reset to 0.
- Reset asserted mid-frame aborts the frame immediately. A partial byte is never delivered.
- serial_in passes through SYNC_STAGES flops; the result is rx_s. All decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when ena=1 and rx_s=0, go to START and clear the cycle counter.
- START: count to CLKS_PER_BIT/2-1 (integer division), then sample rx_s.
  - rx_s=0: go to DATA with bit index 0 and the counter cleared.
  - rx_s=1: treat as a glitch and return to IDLE. No flags change.
- DATA: count to CLKS_PER_BIT-1, then sample rx_s into shift register bit [index]. Data is LSB first.
  - After index 7, go to STOP. Otherwise increment the index.
- STOP: count to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s=1: deliver the byte and return to IDLE. The next start edge can be detected one cycle later.
  - rx_s=0: set frame_err, discard the byte, go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from producing 8'h00 bytes.
- Delivery, in the cycle the stop bit is sampled high:
  - If rx_valid=0, or rx_valid&rx_ready in the same cycle: load rx_data and set rx_valid=1 on the next edge.
  - Otherwise set overrun, drop the new byte, and leave rx_data unchanged.
- Handshake:
  - rx_valid clears on the edge after rx_valid&rx_ready, unless a new byte loads on that same edge, in which case it stays 1.
  - rx_data never changes while rx_valid=1 and rx_ready=0.
- Latency: rx_valid rises 1 cycle after the stop-bit sample point. That point is SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the falling edge at the serial_in pin, within ±1 cycle.
- Error flags:
  - Sticky until err_clr or rst.
  - If err_clr and a new error event occur in the same cycle, the set wins.
  - Errors never block reception of later bytes.
- ena deasserted mid-frame: the FSM returns to IDLE on the next edge and the partial byte is discarded. rx_valid and rx_data are unaffected.
- busy = (state != IDLE).

Test Plan:
(All scenarios use CLKS_PER_BIT=16.)
1. Reset then send 8'hA5 with rx_ready=1 -> rx_valid pulses for 1 cycle with rx_data=8'hA5; frame_err=0, overrun=0, busy low afterwards.
2. Back-to-back 8'h3C, 8'h7F, 8'hC1 with no idle gap, rx_ready=1 -> three valid pulses carrying exactly those bytes in order.
3. rx_ready=0, send 8'h99 then 8'h42 -> rx_data remains 8'h99 and overrun=1. Raise rx_ready -> 8'h99 is consumed once, 8'h42 is never presented. err_clr -> overrun=0.
4. Send 8'hE7 with the stop bit driven low, line held low for 40 cycles, then high -> frame_err=1, no rx_valid, no spurious 8'h00. Next byte 8'hB8 is received correctly.
5. 4-cycle low glitch on an idle line -> FSM returns to IDLE, no rx_valid, no flags set.
6. Assert rst during bit 3 of 8'h5D, release, then send 8'hF0 -> no delivery of the partial byte, outputs at reset values, then rx_data=8'hF0 delivered.
